// File: rtl/demortl_dma64_responder_pkg.sv
// Shared types and constants for the 64-bit DMA responder.
// Holds FSM and arbitration encodings plus the request sanity check.
package demortl_dma64_responder_pkg;

  localparam int unsigned BEAT_W = 64;
  localparam logic [2:0] DMA_SIZE_64 = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  typedef enum logic {
    RR_RD = 1'b0,
    RR_WR = 1'b1
  } rr_e;

  // A request is flagged when it is not 64-bit sized or runs past the end of the store.
  function automatic logic req_bad(input logic [2:0]  size,
                                   input logic [31:0] index,
                                   input logic [31:0] length,
                                   input logic [33:0] words);
    logic [33:0] span;
    span = {2'b00, index} + {2'b00, length};
    return (size != DMA_SIZE_64) || (span > words);
  endfunction

endpackage

// File: rtl/demortl_dma64_responder_if.sv
// Accelerator-facing DMA bus: read/write control and data channels.
// The accelerator is the master; the responder uses the slave modport.
interface demortl_dma64_responder_if;
  import demortl_dma64_responder_pkg::*;

  logic              dma_read_ctrl_valid;
  logic              dma_read_ctrl_ready;
  logic [31:0]       dma_read_ctrl_data_index;
  logic [31:0]       dma_read_ctrl_data_length;
  logic [2:0]        dma_read_ctrl_data_size;
  logic              dma_read_chnl_valid;
  logic              dma_read_chnl_ready;
  logic [BEAT_W-1:0] dma_read_chnl_data;
  logic              dma_write_ctrl_valid;
  logic              dma_write_ctrl_ready;
  logic [31:0]       dma_write_ctrl_data_index;
  logic [31:0]       dma_write_ctrl_data_length;
  logic [2:0]        dma_write_ctrl_data_size;
  logic              dma_write_chnl_valid;
  logic              dma_write_chnl_ready;
  logic [BEAT_W-1:0] dma_write_chnl_data;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

endinterface

// File: rtl/demortl_dma64_responder_mem.sv
// Backing store: one synchronous write port, one asynchronous read port.
// Deliberately unreset so contents survive a responder reset.
module demortl_dma64_mem
  import demortl_dma64_responder_pkg::*;
#(
  parameter int unsigned WORDS  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BEAT_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BEAT_W-1:0] rdata
);

  logic [BEAT_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/demortl_dma64_responder.sv
// DMA responder: serves one read or write burst at a time against a local store,
// alternating grants between channels when both request together.
module demortl_dma64_responder
  import demortl_dma64_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  demortl_dma64_responder_if.slave   dma,
  output logic                       busy,
  output logic                       err,
  output logic [31:0]                rd_beats,
  output logic [31:0]                wr_beats
);

  state_e            state_q, state_d;
  rr_e               rr_q, rr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       remain_q, remain_d;
  logic              rd_valid_q, rd_valid_d;
  logic [BEAT_W-1:0] rd_data_q, rd_data_d;
  logic              err_q, err_d;
  logic [31:0]       rd_beats_q, rd_beats_d;
  logic [31:0]       wr_beats_q, wr_beats_d;

  logic              rd_ctrl_ready, wr_ctrl_ready, wr_chnl_ready;
  logic              rd_pop, mem_we;
  logic [BEAT_W-1:0] mem_rdata;

  demortl_dma64_mem #(.WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (dma.dma_write_chnl_data),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    rd_valid_d    = rd_valid_q;
    rd_data_d     = rd_data_q;
    err_d         = err_q;
    rd_beats_d    = rd_beats_q;
    wr_beats_d    = wr_beats_q;
    rd_ctrl_ready = 1'b0;
    wr_ctrl_ready = 1'b0;
    wr_chnl_ready = 1'b0;
    rd_pop        = 1'b0;
    mem_we        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        rd_ctrl_ready = (rr_q == RR_RD) || !dma.dma_write_ctrl_valid;
        wr_ctrl_ready = (rr_q == RR_WR) || !dma.dma_read_ctrl_valid;
        if (dma.dma_read_ctrl_valid && rd_ctrl_ready) begin
          addr_d   = dma.dma_read_ctrl_data_index[ADDR_W-1:0];
          remain_d = dma.dma_read_ctrl_data_length;
          rr_d     = RR_WR;
          state_d  = ST_RD;
          if (req_bad(dma.dma_read_ctrl_data_size, dma.dma_read_ctrl_data_index,
                      dma.dma_read_ctrl_data_length, 34'(MEM_WORDS))) err_d = 1'b1;
        end else if (dma.dma_write_ctrl_valid && wr_ctrl_ready) begin
          addr_d   = dma.dma_write_ctrl_data_index[ADDR_W-1:0];
          remain_d = dma.dma_write_ctrl_data_length;
          rr_d     = RR_RD;
          state_d  = ST_WR;
          if (req_bad(dma.dma_write_ctrl_data_size, dma.dma_write_ctrl_data_index,
                      dma.dma_write_ctrl_data_length, 34'(MEM_WORDS))) err_d = 1'b1;
        end
      end

      ST_RD: begin
        rd_pop = rd_valid_q && dma.dma_read_chnl_ready;
        if (rd_pop) rd_beats_d = rd_beats_q + 32'd1;
        // Refill the output register whenever it drains, so steady ready gives one beat per cycle.
        if (remain_q != 32'd0 && (!rd_valid_q || dma.dma_read_chnl_ready)) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_rdata;
          addr_d     = addr_q + ADDR_W'(1);
          remain_d   = remain_q - 32'd1;
        end else if (rd_pop) begin
          rd_valid_d = 1'b0;
        end
        if (remain_q == 32'd0 && (!rd_valid_q || rd_pop)) state_d = ST_IDLE;
      end

      ST_WR: begin
        wr_chnl_ready = (remain_q != 32'd0);
        if (dma.dma_write_chnl_valid && wr_chnl_ready) begin
          mem_we     = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
          remain_d   = remain_q - 32'd1;
          wr_beats_d = wr_beats_q + 32'd1;
          if (remain_q == 32'd1) state_d = ST_IDLE;
        end
        if (remain_q == 32'd0) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (dma.dma_write_chnl_valid && state_q != ST_WR) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= RR_RD;
      addr_q     <= '0;
      remain_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      rd_beats_q <= '0;
      wr_beats_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      rd_beats_q <= rd_beats_d;
      wr_beats_q <= wr_beats_d;
    end
  end

  assign dma.dma_read_ctrl_ready  = rd_ctrl_ready;
  assign dma.dma_write_ctrl_ready = wr_ctrl_ready;
  assign dma.dma_write_chnl_ready = wr_chnl_ready;
  assign dma.dma_read_chnl_valid  = rd_valid_q;
  assign dma.dma_read_chnl_data   = rd_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;
  assign rd_beats = rd_beats_q;
  assign wr_beats = wr_beats_q;

endmodule

// File: tb/tb_demortl_dma64_responder.sv
// Directed bench for the DMA responder: bursts, stalls, arbitration, wrap, errors, reset abort.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_demortl_dma64_responder;
  import demortl_dma64_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, err;
  logic [31:0] rd_beats, wr_beats;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] wd [8];
  logic [63:0] ex [8];

  always #5 clk = ~clk;

  demortl_dma64_responder_if bus ();

  demortl_dma64_responder #(.MEM_WORDS(1024), .ADDR_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .dma      (bus),
    .busy     (busy),
    .err      (err),
    .rd_beats (rd_beats),
    .wr_beats (wr_beats)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic init_bus();
    bus.dma_read_ctrl_valid        = 1'b0;
    bus.dma_read_ctrl_data_index   = '0;
    bus.dma_read_ctrl_data_length  = '0;
    bus.dma_read_ctrl_data_size    = DMA_SIZE_64;
    bus.dma_read_chnl_ready        = 1'b0;
    bus.dma_write_ctrl_valid       = 1'b0;
    bus.dma_write_ctrl_data_index  = '0;
    bus.dma_write_ctrl_data_length = '0;
    bus.dma_write_ctrl_data_size   = DMA_SIZE_64;
    bus.dma_write_chnl_valid       = 1'b0;
    bus.dma_write_chnl_data        = '0;
  endtask

  task automatic send_rd_req(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
    int n = 0;
    bus.dma_read_ctrl_valid       = 1'b1;
    bus.dma_read_ctrl_data_index  = idx;
    bus.dma_read_ctrl_data_length = len;
    bus.dma_read_ctrl_data_size   = sz;
    #1;
    while (!bus.dma_read_ctrl_ready && n < 16) begin
      @(negedge clk); #1; n++;
    end
    check_output("rd_ctrl_grant_in_time", 64'(n < 16), 64'd1);
    @(negedge clk);
    bus.dma_read_ctrl_valid = 1'b0;
  endtask

  task automatic send_wr_req(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
    int n = 0;
    bus.dma_write_ctrl_valid       = 1'b1;
    bus.dma_write_ctrl_data_index  = idx;
    bus.dma_write_ctrl_data_length = len;
    bus.dma_write_ctrl_data_size   = sz;
    #1;
    while (!bus.dma_write_ctrl_ready && n < 16) begin
      @(negedge clk); #1; n++;
    end
    check_output("wr_ctrl_grant_in_time", 64'(n < 16), 64'd1);
    @(negedge clk);
    bus.dma_write_ctrl_valid = 1'b0;
  endtask

  task automatic send_wr_beats(input int n, input logic [63:0] data [8]);
    for (int i = 0; i < n; i++) begin
      bus.dma_write_chnl_valid = 1'b1;
      bus.dma_write_chnl_data  = data[i];
      #1;
      check_output("wr_chnl_ready", 64'(bus.dma_write_chnl_ready), 64'd1);
      @(negedge clk);
    end
    bus.dma_write_chnl_valid = 1'b0;
  endtask

  // Drives the ready pattern (bit i used on cycle i mod 4) and checks each accepted beat in order.
  task automatic collect_read(input string tag, input int n, input logic [63:0] exp [8],
                              input logic [3:0] pat, input int exp_span);
    int got = 0, cyc = 0, first_acc = -1, first_vld = -1;
    logic prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic r;
    check_output({tag, "_valid_at_entry"}, 64'(bus.dma_read_chnl_valid), 64'd0);
    while (got < n && cyc < 64) begin
      r = pat[cyc % 4];
      bus.dma_read_chnl_ready = r;
      if (prev_stall) begin
        check_output({tag, "_stall_valid"}, 64'(bus.dma_read_chnl_valid), 64'd1);
        check_output({tag, "_stall_data"}, bus.dma_read_chnl_data, prev_data);
      end
      if (bus.dma_read_chnl_valid && first_vld < 0) first_vld = cyc;
      if (bus.dma_read_chnl_valid && r) begin
        check_output({tag, "_beat_data"}, bus.dma_read_chnl_data, exp[got]);
        if (first_acc < 0) first_acc = cyc;
        got++;
      end
      prev_stall = bus.dma_read_chnl_valid && !r;
      prev_data  = bus.dma_read_chnl_data;
      @(negedge clk);
      cyc++;
    end
    bus.dma_read_chnl_ready = 1'b0;
    check_output({tag, "_beat_count"}, 64'(got), 64'(n));
    check_output({tag, "_first_valid_cycle"}, 64'(first_vld), 64'd1);
    check_output({tag, "_span"}, 64'(cyc - first_acc), 64'(exp_span));
    check_output({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_idle_valid"}, 64'(bus.dma_read_chnl_valid), 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    logic saw = 1'b0;
    while (busy && n < 50) begin
      if (bus.dma_read_chnl_valid) saw = 1'b1;
      @(negedge clk);
      n++;
    end
    check_output({tag, "_idle_in_time"}, 64'(n < 50), 64'd1);
    check_output({tag, "_no_read_beat"}, 64'(saw), 64'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    init_bus();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_err", 64'(err), 64'd0);
    check_output("rst_rd_beats", 64'(rd_beats), 64'd0);
    check_output("rst_wr_beats", 64'(wr_beats), 64'd0);
    check_output("rst_rd_valid", 64'(bus.dma_read_chnl_valid), 64'd0);
    check_output("rst_rd_data", bus.dma_read_chnl_data, 64'd0);
    check_output("rst_rd_ctrl_ready", 64'(bus.dma_read_ctrl_ready), 64'd1);
    check_output("rst_wr_ctrl_ready", 64'(bus.dma_write_ctrl_ready), 64'd1);

    // Simultaneous zero-length requests: read wins first, then write.
    bus.dma_read_ctrl_valid  = 1'b1;
    bus.dma_write_ctrl_valid = 1'b1;
    #1;
    check_output("arb1_rd_ready", 64'(bus.dma_read_ctrl_ready), 64'd1);
    check_output("arb1_wr_ready", 64'(bus.dma_write_ctrl_ready), 64'd0);
    @(negedge clk);
    init_bus();
    check_output("len0_rd_busy", 64'(busy), 64'd1);
    wait_idle("len0_rd");
    bus.dma_read_ctrl_valid  = 1'b1;
    bus.dma_write_ctrl_valid = 1'b1;
    #1;
    check_output("arb2_rd_ready", 64'(bus.dma_read_ctrl_ready), 64'd0);
    check_output("arb2_wr_ready", 64'(bus.dma_write_ctrl_ready), 64'd1);
    @(negedge clk);
    init_bus();
    wait_idle("len0_wr");
    check_output("arb_rd_beats", 64'(rd_beats), 64'd0);
    check_output("arb_wr_beats", 64'(wr_beats), 64'd0);
    check_output("arb_err", 64'(err), 64'd0);

    // Four-beat write then full-rate read back.
    wd = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h0, 64'h0, 64'h0, 64'h0};
    send_wr_req(32'd0, 32'd4, DMA_SIZE_64);
    send_wr_beats(4, wd);
    check_output("wr4_idle", 64'(busy), 64'd0);
    send_rd_req(32'd0, 32'd4, DMA_SIZE_64);
    collect_read("rd4", 4, wd, 4'b1111, 4);
    check_output("rd4_rd_beats", 64'(rd_beats), 64'd4);
    check_output("rd4_wr_beats", 64'(wr_beats), 64'd4);
    check_output("rd4_err", 64'(err), 64'd0);

    // Stalled read with ready 1,0,0,1 repeating.
    ex = '{64'h22, 64'h33, 64'h44, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    send_rd_req(32'd1, 32'd3, DMA_SIZE_64);
    collect_read("rd_stall", 3, ex, 4'b1001, 5);
    check_output("rd_stall_rd_beats", 64'(rd_beats), 64'd7);

    // Write past the end of the store wraps and flags an error.
    wd = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'h0, 64'h0, 64'h0, 64'h0};
    send_wr_req(32'd1022, 32'd4, DMA_SIZE_64);
    send_wr_beats(4, wd);
    check_output("wrap_err", 64'(err), 64'd1);
    check_output("wrap_wr_beats", 64'(wr_beats), 64'd8);
    pulse_reset();
    check_output("wrap_rst_err", 64'(err), 64'd0);
    ex = '{64'hA0, 64'hA1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    send_rd_req(32'd1022, 32'd2, DMA_SIZE_64);
    collect_read("wrap_top", 2, ex, 4'b1111, 2);
    check_output("edge_no_err", 64'(err), 64'd0);
    ex = '{64'hA2, 64'hA3, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    send_rd_req(32'd0, 32'd2, DMA_SIZE_64);
    collect_read("wrap_bottom", 2, ex, 4'b1111, 2);

    // Wrong size still moves a 64-bit beat but flags an error.
    wd = '{64'h55, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    send_wr_req(32'd5, 32'd1, 3'b010);
    send_wr_beats(1, wd);
    check_output("size_err", 64'(err), 64'd1);
    check_output("size_wr_beats", 64'(wr_beats), 64'd1);
    send_rd_req(32'd5, 32'd1, DMA_SIZE_64);
    collect_read("size_rd", 1, wd, 4'b1111, 1);
    check_output("size_rd_beats", 64'(rd_beats), 64'd5);

    // Reset during beat 2 of an 8-beat read.
    pulse_reset();
    wd = '{64'h80, 64'h81, 64'h82, 64'h83, 64'h84, 64'h85, 64'h86, 64'h87};
    send_wr_req(32'd8, 32'd8, DMA_SIZE_64);
    send_wr_beats(8, wd);
    send_rd_req(32'd8, 32'd8, DMA_SIZE_64);
    bus.dma_read_chnl_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("abort_beat2_data", bus.dma_read_chnl_data, 64'h81);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.dma_read_chnl_ready = 1'b0;
    check_output("abort_valid", 64'(bus.dma_read_chnl_valid), 64'd0);
    check_output("abort_data", bus.dma_read_chnl_data, 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_rd_beats", 64'(rd_beats), 64'd0);
    check_output("abort_wr_beats", 64'(wr_beats), 64'd0);
    send_rd_req(32'd8, 32'd8, DMA_SIZE_64);
    collect_read("abort_mem_intact", 8, wd, 4'b1111, 8);

    // Stray write data outside a write burst: error, memory untouched.
    send_rd_req(32'd8, 32'd1, DMA_SIZE_64);
    collect_read("pre_stray", 1, wd, 4'b1111, 1);
    bus.dma_write_chnl_valid = 1'b1;
    bus.dma_write_chnl_data  = 64'hDEAD;
    @(negedge clk);
    bus.dma_write_chnl_valid = 1'b0;
    check_output("stray_err", 64'(err), 64'd1);
    check_output("stray_wr_beats", 64'(wr_beats), 64'd0);
    ex = '{64'h81, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    send_rd_req(32'd9, 32'd1, DMA_SIZE_64);
    collect_read("stray_mem", 1, ex, 4'b1111, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
